// File: rtl/regfile_host_controller_if.sv
// Host pin bundle for regfile_host_controller.
//   master : host side, drives frame/strobe/data and observes read-back, ready, error
//   slave  : controller side
// Ports:
//   i_host_frame   high for the duration of one transaction (asynchronous pin)
//   i_host_strobe  each rising edge presents one byte (asynchronous pin)
//   i_host_data    host byte, held stable from strobe rise until o_host_ready falls
//   o_host_data    read-back byte
//   o_host_ready   controller will accept the next strobe
//   o_host_error   illegal address seen in the current frame
interface regfile_host_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_host_frame;
  logic                  i_host_strobe;
  logic [DATA_WIDTH-1:0] i_host_data;
  logic [DATA_WIDTH-1:0] o_host_data;
  logic                  o_host_ready;
  logic                  o_host_error;

  modport master (
    output i_host_frame,
    output i_host_strobe,
    output i_host_data,
    input  o_host_data,
    input  o_host_ready,
    input  o_host_error
  );

  modport slave (
    input  i_host_frame,
    input  i_host_strobe,
    input  i_host_data,
    output o_host_data,
    output o_host_ready,
    output o_host_error
  );
endinterface

// File: rtl/regfile_host_controller.sv
// Host-side sequencer for the PWM peripheral register file.
// Turns a strobed byte protocol (command byte, then data bytes, optional address
// auto-increment) into single-cycle register-file writes/reads, and emits a
// one-cycle commit pulse at the end of any frame that wrote a register.
//
// Ports:
//   i_clk           system clock
//   i_reset_n       asynchronous assert, synchronous release, active low
//   host            host pin bundle (slave modport)
//   o_rf_write_en   register-file write enable
//   o_rf_address    register-file address (holds between accesses)
//   o_rf_data       register-file write data
//   i_rf_data       register-file read data, combinational from o_rf_address
//   o_update_pulse  one-cycle commit after a frame that wrote at least one register
//
// Command byte: bit7 write(1)/read(0), bit6 auto-increment, bit5 ignored,
// bits[ADDRESS_WIDTH-1:0] start address.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no frame; waiting for frame rise
// S_CMD     | frame open; waiting for the command byte
// S_WDATA   | waiting for the next write data byte
// S_WCOMMIT | write enable high for this single cycle
// S_RFETCH  | capture register-file read data into the read-back byte
// S_RWAIT   | read-back byte valid; next strobe means it was consumed
// S_ERR     | illegal address; strobes ignored until frame end
module regfile_host_controller #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REGS      = 15,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  regfile_host_controller_if.slave host,
  output logic                     o_rf_write_en,
  output logic [ADDRESS_WIDTH-1:0] o_rf_address,
  output logic [DATA_WIDTH-1:0]    o_rf_data,
  input  logic [DATA_WIDTH-1:0]    i_rf_data,
  output logic                     o_update_pulse
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_WCOMMIT = 3'd3;
  localparam logic [2:0] S_RFETCH  = 3'd4;
  localparam logic [2:0] S_RWAIT   = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  // A single-flop synchronizer is never acceptable; clamp to two.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // One extra bit so NUM_REGS == 2**ADDRESS_WIDTH still compares correctly.
  localparam logic [ADDRESS_WIDTH:0]   NUM_REGS_EXT = (ADDRESS_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR    = ADDRESS_WIDTH'(NUM_REGS - 1);

  logic [SYNC_N-1:0]        frame_sync_q, frame_sync_d;
  logic [SYNC_N-1:0]        strobe_sync_q, strobe_sync_d;
  logic                     frame_prev_q, frame_prev_d;
  logic                     strobe_prev_q, strobe_prev_d;
  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     ai_q, ai_d;
  logic                     written_q, written_d;
  logic                     error_q, error_d;
  logic                     update_q, update_d;

  logic                     frame_rise;
  logic                     frame_fall;
  logic                     strobe_rise;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic                     cmd_addr_ok;
  logic [ADDRESS_WIDTH-1:0] addr_next;

  // Synchronizers and edge detectors
  always_comb begin
    frame_sync_d  = {frame_sync_q[SYNC_N-2:0], host.i_host_frame};
    strobe_sync_d = {strobe_sync_q[SYNC_N-2:0], host.i_host_strobe};
    frame_prev_d  = frame_sync_q[SYNC_N-1];
    strobe_prev_d = strobe_sync_q[SYNC_N-1];
  end

  assign frame_rise  =  frame_sync_q[SYNC_N-1]  & ~frame_prev_q;
  assign frame_fall  = ~frame_sync_q[SYNC_N-1]  &  frame_prev_q;
  assign strobe_rise =  strobe_sync_q[SYNC_N-1] & ~strobe_prev_q;

  assign cmd_addr    = host.i_host_data[ADDRESS_WIDTH-1:0];
  assign cmd_addr_ok = ({1'b0, cmd_addr} < NUM_REGS_EXT);
  // Wrap at the last implemented register, not at 2**ADDRESS_WIDTH.
  assign addr_next   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDRESS_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ai_d      = ai_q;
    written_d = written_q;
    error_d   = error_q;
    update_d  = 1'b0;

    if ((state_q != S_IDLE) && frame_fall) begin
      // Frame end takes priority over a coincident strobe; that byte is dropped.
      // A write already in its commit cycle still happens and counts.
      state_d   = S_IDLE;
      update_d  = written_q | (state_q == S_WCOMMIT);
      written_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_rise) begin
            state_d = S_CMD;
            error_d = 1'b0;
          end
        end
        S_CMD: begin
          if (strobe_rise) begin
            addr_d = cmd_addr;
            ai_d   = host.i_host_data[6];
            if (!cmd_addr_ok) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else if (host.i_host_data[7]) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_RFETCH;
            end
          end
        end
        S_WDATA: begin
          if (strobe_rise) begin
            wdata_d = host.i_host_data;
            state_d = S_WCOMMIT;
          end
        end
        S_WCOMMIT: begin
          written_d = 1'b1;
          if (ai_q) begin
            addr_d = addr_next;
          end
          state_d = S_WDATA;
        end
        S_RFETCH: begin
          rdata_d = i_rf_data;
          state_d = S_RWAIT;
        end
        S_RWAIT: begin
          if (strobe_rise) begin
            if (ai_q) begin
              addr_d = addr_next;
            end
            state_d = S_RFETCH;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_sync_q  <= '0;
      strobe_sync_q <= '0;
      frame_prev_q  <= 1'b0;
      strobe_prev_q <= 1'b0;
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      ai_q          <= 1'b0;
      written_q     <= 1'b0;
      error_q       <= 1'b0;
      update_q      <= 1'b0;
    end else begin
      frame_sync_q  <= frame_sync_d;
      strobe_sync_q <= strobe_sync_d;
      frame_prev_q  <= frame_prev_d;
      strobe_prev_q <= strobe_prev_d;
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      ai_q          <= ai_d;
      written_q     <= written_d;
      error_q       <= error_d;
      update_q      <= update_d;
    end
  end

  assign o_rf_write_en     = (state_q == S_WCOMMIT);
  assign o_rf_address      = addr_q;
  assign o_rf_data         = wdata_q;
  assign o_update_pulse    = update_q;
  assign host.o_host_data  = rdata_q;
  assign host.o_host_error = error_q;
  assign host.o_host_ready = (state_q == S_CMD) || (state_q == S_WDATA) ||
                             (state_q == S_RWAIT);

endmodule

// File: tb/tb_regfile_host_controller.sv
module tb_regfile_host_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       o_rf_write_en;
  logic [4:0] o_rf_address;
  logic [7:0] o_rf_data;
  logic [7:0] i_rf_data;
  logic       o_update_pulse;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  int ready_in_commit = 0;
  logic [4:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];
  logic [7:0] rf_mem [0:31];

  always #5 clk = ~clk;

  regfile_host_controller_if #(.DATA_WIDTH(8)) host ();

  regfile_host_controller #(
    .ADDRESS_WIDTH(5), .DATA_WIDTH(8), .NUM_REGS(15), .SYNC_STAGES(2)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .host           (host),
    .o_rf_write_en  (o_rf_write_en),
    .o_rf_address   (o_rf_address),
    .o_rf_data      (o_rf_data),
    .i_rf_data      (i_rf_data),
    .o_update_pulse (o_update_pulse)
  );

  // Simple register file behind the controller
  always @(posedge clk) begin
    if (o_rf_write_en) rf_mem[o_rf_address] <= o_rf_data;
  end
  always_comb i_rf_data = (o_rf_address < 5'd15) ? rf_mem[o_rf_address] : 8'h00;

  // Observe writes and commit pulses mid-cycle
  always @(negedge clk) begin
    if (o_rf_write_en) begin
      wr_addr_log.push_back(o_rf_address);
      wr_data_log.push_back(o_rf_data);
      if (host.o_host_ready) ready_in_commit++;
    end
    if (o_update_pulse) upd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (host.o_host_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, host.o_host_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit need_ready);
    if (need_ready) wait_ready("ready_before_strobe");
    host.i_host_data   = b;
    host.i_host_strobe = 1'b1;
    repeat (4) @(negedge clk);
    host.i_host_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_start();
    host.i_host_frame = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    host.i_host_frame = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [4:0] a, input logic [7:0] d);
    check({tag, "_addr"}, (idx < wr_addr_log.size()) ? 32'(wr_addr_log[idx]) : 32'hFFFF, 32'(a));
    check({tag, "_data"}, (idx < wr_data_log.size()) ? 32'(wr_data_log[idx]) : 32'hFFFF, 32'(d));
  endtask

  initial begin
    int u0;
    int w0;
    host.i_host_frame  = 1'b0;
    host.i_host_strobe = 1'b0;
    host.i_host_data   = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write_en", o_rf_write_en, 0);
    check("rst_address", o_rf_address, 0);
    check("rst_rf_data", o_rf_data, 0);
    check("rst_host_data", host.o_host_data, 0);
    check("rst_ready", host.o_host_ready, 0);
    check("rst_error", host.o_host_error, 0);
    check("rst_update", o_update_pulse, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", host.o_host_ready, 0);

    // Burst write: cmd 0xC0, data 0x05 0x01 0x80
    frame_start();
    send_byte(8'hC0, 1);
    wait_ready("wdata_ready");
    host.i_host_data   = 8'h05;
    host.i_host_strobe = 1'b1;
    repeat (2) @(negedge clk);
    check("wen_not_early", o_rf_write_en, 0);
    @(negedge clk);
    check("wen_latency", o_rf_write_en, 1);
    check("wen0_addr", o_rf_address, 5'd0);
    check("wen0_data", o_rf_data, 8'h05);
    check("ready_low_commit", host.o_host_ready, 0);
    @(negedge clk);
    check("wen_one_cycle", o_rf_write_en, 0);
    check("ready_back_wdata", host.o_host_ready, 1);
    check("ai_addr_1", o_rf_address, 5'd1);
    host.i_host_strobe = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h01, 1);
    send_byte(8'h80, 1);
    check("burst_wr_count", wr_addr_log.size(), 3);
    check_write("burst_w1", 1, 5'd1, 8'h01);
    check_write("burst_w2", 2, 5'd2, 8'h80);
    check("burst_addr_after", o_rf_address, 5'd3);
    u0 = upd_cnt;
    frame_end();
    check("burst_update_once", upd_cnt - u0, 1);
    check("idle_no_update", o_update_pulse, 0);

    // Read-back: cmd 0x41 (read, AI, addr 1)
    frame_start();
    w0 = wr_addr_log.size();
    u0 = upd_cnt;
    wait_ready("cmd_ready_rd");
    host.i_host_data   = 8'h41;
    host.i_host_strobe = 1'b1;
    repeat (3) @(negedge clk);
    check("rfetch_ready_low", host.o_host_ready, 0);
    @(negedge clk);
    check("rd_latency_ready", host.o_host_ready, 1);
    check("rd_data_1", host.o_host_data, 8'h01);
    host.i_host_strobe = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h00, 1);
    check("rd_data_2", host.o_host_data, 8'h80);
    check("rd_addr_2", o_rf_address, 5'd2);
    check("rd_ready_2", host.o_host_ready, 1);
    frame_end();
    check("rd_no_writes", wr_addr_log.size() - w0, 0);
    check("rd_no_update", upd_cnt - u0, 0);

    // Auto-increment wrap: cmd 0xCE (addr 14), 0xAA, 0x55
    frame_start();
    w0 = wr_addr_log.size();
    u0 = upd_cnt;
    send_byte(8'hCE, 1);
    send_byte(8'hAA, 1);
    send_byte(8'h55, 1);
    check("wrap_wr_count", wr_addr_log.size() - w0, 2);
    check_write("wrap_w14", w0, 5'd14, 8'hAA);
    check_write("wrap_w0", w0 + 1, 5'd0, 8'h55);
    frame_end();
    check("wrap_update", upd_cnt - u0, 1);

    // Illegal address: cmd 0x9F (addr 31)
    frame_start();
    w0 = wr_addr_log.size();
    u0 = upd_cnt;
    send_byte(8'h9F, 1);
    check("err_set", host.o_host_error, 1);
    check("err_ready_low", host.o_host_ready, 0);
    send_byte(8'h33, 0);
    check("err_no_write", wr_addr_log.size() - w0, 0);
    frame_end();
    check("err_holds_after_frame", host.o_host_error, 1);
    check("err_no_update", upd_cnt - u0, 0);

    // Next frame clears the error; then frame falls with the data strobe
    frame_start();
    check("err_cleared", host.o_host_error, 0);
    check("new_frame_ready", host.o_host_ready, 1);
    send_byte(8'h80, 1);
    host.i_host_data   = 8'hEE;
    host.i_host_strobe = 1'b1;
    host.i_host_frame  = 1'b0;
    repeat (6) @(negedge clk);
    host.i_host_strobe = 1'b0;
    repeat (4) @(negedge clk);
    check("race_no_write", wr_addr_log.size() - w0, 0);
    check("race_no_update", upd_cnt - u0, 0);
    check("race_idle_ready", host.o_host_ready, 0);

    // Reset mid-burst after one committed write
    frame_start();
    w0 = wr_addr_log.size();
    send_byte(8'hC3, 1);
    send_byte(8'h11, 1);
    check("mid_wr_count", wr_addr_log.size() - w0, 1);
    check_write("mid_w3", w0, 5'd3, 8'h11);
    u0 = upd_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_address", o_rf_address, 0);
    check("mid_rst_rf_data", o_rf_data, 0);
    check("mid_rst_host_data", host.o_host_data, 0);
    check("mid_rst_ready", host.o_host_ready, 0);
    check("mid_rst_write_en", o_rf_write_en, 0);
    host.i_host_frame = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_no_update", upd_cnt - u0, 0);

    // Normal frame after reset: cmd 0x82, data 0x77
    frame_start();
    w0 = wr_addr_log.size();
    send_byte(8'h82, 1);
    send_byte(8'h77, 1);
    check("post_rst_wr_count", wr_addr_log.size() - w0, 1);
    check_write("post_rst_w2", w0, 5'd2, 8'h77);
    frame_end();
    check("post_rst_update", upd_cnt - u0, 1);

    check("ready_never_in_commit", ready_in_commit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_host_controller.md
Name: regfile_host_controller

Overview:
- Host-side sequencer for the PWM peripheral register file. Owns the register file's i_write_en, i_address and i_data inputs.
- Converts a strobed 8-bit pin protocol (command byte, then data bytes, optional address auto-increment) into single-cycle register-file writes and reads.
- Issues a one-cycle commit pulse at frame end so the PWM channels can load their shadow registers atomically.

Parameters:
- ADDRESS_WIDTH, 5, width of register-file address.
- DATA_WIDTH, 8, register and host byte width.
- NUM_REGS, 15, number of implemented registers. Valid addresses are 0..NUM_REGS-1.
- SYNC_STAGES, 2, flip-flops in each pin synchronizer (minimum 2).

Ports:
- i_clk  input  1  system clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_host_frame  input  1  async pin; high for the duration of one transaction.
- i_host_strobe  input  1  async pin; each rising edge presents one byte.
- i_host_data  input  DATA_WIDTH  host byte; stable from strobe rise until o_host_ready falls.
- o_host_data  output  DATA_WIDTH  read-back byte.
- o_host_ready  output  1  high = controller will accept the next strobe.
- o_host_error  output  1  illegal address in current frame.
- o_rf_write_en  output  1  register-file write enable.
- o_rf_address  output  ADDRESS_WIDTH  register-file address.
- o_rf_data  output  DATA_WIDTH  register-file write data.
- i_rf_data  input  DATA_WIDTH  register-file read data (combinational from o_rf_address).
- o_update_pulse  output  1  one-cycle commit after a frame that wrote at least one register.

Behaviour:
- Reset: state IDLE, synchronizers cleared, every output 0, written flag cleared. Asynchronous assert, synchronous release. Reset mid-frame aborts: no write, no update pulse.
- Pin synchronization: frame and strobe each pass through SYNC_STAGES flops, then a registered edge detector.
  - strobe_rise and frame_rise/frame_fall pulses are valid SYNC_STAGES cycles after the first i_clk edge sampling the new pin level.
  - i_host_data is captured directly on the strobe_rise cycle; the host holds it stable.
- Command byte: bit7 = 1 write / 0 read; bit6 = auto-increment (AI); bit5 ignored; bits[ADDRESS_WIDTH-1:0] = start address.
- FSM states: IDLE, CMD, WDATA, WCOMMIT, RFETCH, RWAIT, ERR.
  - IDLE: on frame_rise go to CMD, clear o_host_error.
  - CMD: on strobe_rise latch the command into o_rf_address/flags.
    - Address >= NUM_REGS: go to ERR, set o_host_error.
    - Otherwise write goes to WDATA, read goes to RFETCH.
  - WDATA: on strobe_rise latch i_host_data into o_rf_data, go to WCOMMIT.
  - WCOMMIT: o_rf_write_en=1 for exactly one cycle; set written flag; go to WDATA. With AI, the address advances on exit (NUM_REGS-1 wraps to 0).
  - RFETCH: one cycle; o_host_data <= i_rf_data; go to RWAIT.
  - RWAIT: on strobe_rise (host consumed byte) advance the address if AI, go to RFETCH. Without AI, re-read the same address.
  - ERR: ignore strobes.
- Frame end: frame_fall in any non-IDLE state goes to IDLE.
  - If the written flag is set, o_update_pulse=1 the following cycle, then the flag clears.
  - frame_fall coincident with strobe_rise: frame_fall wins; the byte is discarded.
  - frame_fall during WCOMMIT: that write still completes and counts toward the update.
- o_host_ready = 1 in CMD, WDATA and RWAIT; 0 elsewhere (including IDLE and ERR).
- o_rf_write_en is never high outside WCOMMIT. o_rf_address holds its value between accesses. o_host_error stays set until the next frame_rise.
- Write latency: o_rf_write_en is high in the cycle after the strobe_rise cycle, i.e. SYNC_STAGES+1 cycles after the first sampling edge of the strobe pin.
- Read latency: o_host_data is valid and o_host_ready rises 2 cycles after the command strobe_rise.
- Address arithmetic: ADDRESS_WIDTH bits, compared against NUM_REGS; wrap is explicit, not modulo 2^ADDRESS_WIDTH.

Test Plan:
- Burst write: frame, cmd 0xC0, data 0x05, 0x01, 0x80 -> three write_en pulses at addr 0/1/2 with those data; frame drop -> o_update_pulse exactly one cycle; ready low in WCOMMIT.
- Read-back: after the burst, frame, cmd 0x41 -> o_host_data=0x01 with ready; strobe -> 0x80; read-only frame end -> no update pulse.
- AI wrap: cmd 0xCE (addr 14), data 0xAA, 0x55 -> writes 14=0xAA then 0=0x55.
- Illegal address: cmd 0x9F -> o_host_error=1, ready=0, later strobes produce no write_en; next frame_rise clears error.
- Race: frame falls in the same synchronized cycle as a data strobe -> no write_en; no update pulse if nothing was written earlier.
- Reset mid-burst: assert i_reset_n=0 while in WDATA after one committed write -> all outputs 0 immediately, no update pulse; after release, a new frame operates normally.
